cic_decimation_rx: RTL and testbench
====================================

CIC_DECIMATION_RX -- requirements
Module: cic_decimation_rx

Interface
REQ-001 SHALL have no parameters: decimation factor R=8, order N=3, differential delay M=1, all fixed.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clr, input, 1 bit: synchronous soft clear.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is accepted on each rising edge where in_valid=1 and clr=0.
REQ-006 SHALL have port in_data, input, 11 bits, signed: Rx input sample.
REQ-007 SHALL have port out_valid, output, 1 bit: one-cycle strobe marking a decimated output.
REQ-008 SHALL have port out_data, output, 20 bits, signed: full-precision decimated sample, gain 512.
REQ-009 SHALL have port out_q, output, 11 bits, signed: out_data rounded and rescaled to the input scale.
REQ-010 SHALL have port phase, output, 3 bits: count of accepted samples modulo 8.

Function
REQ-011 SHALL implement y[m] = sum over n=0..21 of h[n]*x[8m+7-n], with h = coefficients of (1+z^-1+...+z^-7)^3.
- h = 1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1; sum 512.
- x[k]=0 for k<0, where k counts accepted samples since the last reset or clr.
REQ-012 SHALL be the receive-side counterpart of the Tx polyphase interpolation branches.
- Polyphase coefficient sums 120/336/56 apply per decimated output.
REQ-013 SHALL use three integrators at the input rate, decimation by 8, then three combs at the output rate (Hogenauer structure).
REQ-014 SHALL hold every integrator and comb register at 20 bits two's complement; wrap-around is intended and yields an exact result.
REQ-015 SHALL sign-extend in_data to 20 bits before the first integrator.
REQ-016 SHALL update the integrators only on accepted samples; they hold when in_valid=0.
REQ-017 SHALL advance phase by 1 per accepted sample, wrapping 7->0.
REQ-018 SHALL generate a decimation event on acceptance of the sample with phase=7, latching that cycle's third-integrator result, which includes that sample.
REQ-019 SHALL update comb stage k (k=1..3) and its delay register only on the k-th edge after the decimation event.
- Gaps in in_valid SHALL NOT corrupt comb state.
REQ-020 SHALL register out_data and pulse out_valid high for exactly one cycle on the 3rd rising edge after the accepting edge (latency 3 clk).
- out_data holds until the next out_valid.
REQ-021 SHALL compute out_q = (out_data + 256) >>> 9 (round half up), saturated to [-1024, 1023], registered together with out_data.
REQ-022 SHALL sustain in_valid=1 every cycle with no stall; the output rate is 1 per 8 accepted samples.
REQ-023 SHALL give clr priority over in_valid in the same cycle: the sample is dropped.
REQ-024 SHALL make clr zero all integrators, combs, delay registers, pipeline flags, phase, out_data, out_q and out_valid on the next edge.
- clr also discards in-flight decimation events.
REQ-025 SHALL have no backpressure input; the consumer must take out_data when out_valid=1.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force out_valid=0, out_data=0, out_q=0, phase=0, and all internal registers to 0.
REQ-027 SHALL resume acceptance on the first rising edge after rst_n deasserts.
REQ-028 SHALL leave no partial output pending when reset asserts mid-frame; the first post-reset output uses only post-reset samples.

Verification
REQ-029 DC: in_data=100 with in_valid every cycle.
- out_data sequence 12000, 45600, then 51200 repeating.
- out_q sequence 23, 89, then 100 repeating.
- out_valid every 8 cycles, 3 cycles after phase-7 acceptance.
REQ-030 Impulse: x[7]=1, all other samples 0 -> out_data 1, 42, 21, then 0.
REQ-031 Extremes: constant -1024 -> steady out_data=-524288, out_q=-1024; constant 1023 -> steady 523776, out_q=1023; no error from integrator wrap over more than 10k samples.
REQ-032 Gapped input: DC 100 with in_valid randomly 30% duty -> identical out_data sequence to REQ-029, with one out_valid per 8 accepted samples.
REQ-033 clr asserted with in_valid=1 at phase=5 -> that sample dropped, phase=0 next cycle, no out_valid from the aborted frame, next outputs match a fresh start.
REQ-034 rst_n pulsed low for 1 cycle mid-frame with a decimation event in flight -> outputs read 0 immediately with out_valid never asserted, then the REQ-029 sequence restarts.

Source files
------------

// File: rtl/cic_decimation_rx.sv
`timescale 1ns/1ps
// Rx CIC decimator: R=8, N=3, M=1, 20-bit Hogenauer datapath (gain 512).
// Integrators run at the input rate, and each comb stage fires on its own edge after a decimation event.
module cic_decimation_rx (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic signed [10:0] in_data,
  output logic               out_valid,
  output logic signed [19:0] out_data,
  output logic signed [10:0] out_q,
  output logic [2:0]         phase
);

  localparam int W = 20;

  logic signed [W-1:0] r_i1, r_i2, r_i3;
  logic signed [W-1:0] r_dec;
  logic signed [W-1:0] r_c1, r_c2;
  logic signed [W-1:0] r_d1, r_d2, r_d3;
  logic signed [W-1:0] r_out;
  logic signed [10:0]  r_q;
  logic [2:0]          r_phase;
  logic                r_v0, r_v1, r_v2, r_out_valid;

  logic                w_accept;
  logic                w_dec_evt;
  logic signed [W-1:0] w_x, w_i1, w_i2, w_i3;
  logic signed [W-1:0] w_comb3;
  logic signed [W:0]   w_round;
  logic signed [W:0]   w_shift;
  logic signed [10:0]  w_q;

  assign w_accept  = in_valid & ~clr;
  assign w_dec_evt = w_accept & (r_phase == 3'd7);

  // The cascade is combinational so the latched value already includes the phase-7 sample.
  assign w_x  = {{(W-11){in_data[10]}}, in_data};
  assign w_i1 = r_i1 + w_x;
  assign w_i2 = r_i2 + w_i1;
  assign w_i3 = r_i3 + w_i2;

  assign w_comb3 = r_c2 - r_d3;
  assign w_round = {w_comb3[W-1], w_comb3} + 21'sd256;
  assign w_shift = w_round >>> 9;

  always_comb begin
    w_q = w_shift[10:0];
    if (w_shift > 21'sd1023)
      w_q = 11'sd1023;
    else if (w_shift < -21'sd1024)
      w_q = -11'sd1024;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i1        <= '0;
      r_i2        <= '0;
      r_i3        <= '0;
      r_dec       <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_d3        <= '0;
      r_out       <= '0;
      r_q         <= '0;
      r_phase     <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_i1        <= '0;
      r_i2        <= '0;
      r_i3        <= '0;
      r_dec       <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_d3        <= '0;
      r_out       <= '0;
      r_q         <= '0;
      r_phase     <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_i1    <= w_i1;
        r_i2    <= w_i2;
        r_i3    <= w_i3;
        r_phase <= r_phase + 3'd1;
      end
      if (w_dec_evt)
        r_dec <= w_i3;
      r_v0 <= w_dec_evt;

      r_v1 <= r_v0;
      if (r_v0) begin
        r_c1 <= r_dec - r_d1;
        r_d1 <= r_dec;
      end

      r_v2 <= r_v1;
      if (r_v1) begin
        r_c2 <= r_c1 - r_d2;
        r_d2 <= r_c1;
      end

      r_out_valid <= r_v2;
      if (r_v2) begin
        r_out <= w_comb3;
        r_d3  <= r_c2;
        r_q   <= w_q;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign out_q     = r_q;
  assign phase     = r_phase;

endmodule

// File: tb/tb_cic_decimation_rx.sv
`timescale 1ns/1ps
// Directed bench for cic_decimation_rx: DC, impulse, extremes, gapped input, clr and mid-frame reset.
module tb_cic_decimation_rx;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic signed [10:0] in_data;
  logic               out_valid;
  logic signed [19:0] out_data;
  logic signed [10:0] out_q;
  logic [2:0]         phase;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int q_data[$];
  int q_q[$];
  int q_cyc[$];
  int ev_exp[$];

  cic_decimation_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_q    (out_q),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock and log any output strobe plus the expected strobe time.
  task automatic step();
    logic acc;
    acc = in_valid && !clr && rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && clr) n_acc = 0;
    if (acc) begin
      n_acc++;
      if (n_acc % 8 == 0) ev_exp.push_back(cyc + 3);
    end
    if (out_valid === 1'b1) begin
      q_data.push_back(int'(out_data));
      q_q.push_back(int'(out_q));
      q_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_rec();
    q_data.delete();
    q_q.delete();
    q_cyc.delete();
    ev_exp.delete();
    cyc   = 0;
    n_acc = 0;
  endtask

  task automatic fresh();
    in_valid = 1'b0;
    in_data  = '0;
    clr      = 1'b1;
    step();
    clr = 1'b0;
    clear_rec();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 20'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++; if (out_q !== 11'sd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", out_q); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_dc();
    int exp_d[6] = '{12000, 45600, 51200, 51200, 51200, 51200};
    int exp_q[6] = '{23, 89, 100, 100, 100, 100};
    fresh();
    in_valid = 1'b1;
    in_data  = 11'sd100;
    repeat (48) step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL dc_phase: got %0d expected 0", phase); end
    checks++; if (q_data.size() != 6) begin errors++; $display("FAIL dc_count: got %0d expected 6", q_data.size()); end
    for (int m = 0; m < 6 && m < q_data.size(); m++) begin
      checks++; if (q_data[m] != exp_d[m]) begin errors++; $display("FAIL dc_data[%0d]: got %0d expected %0d", m, q_data[m], exp_d[m]); end
      checks++; if (q_q[m] != exp_q[m]) begin errors++; $display("FAIL dc_q[%0d]: got %0d expected %0d", m, q_q[m], exp_q[m]); end
      checks++; if (q_cyc[m] != 8*m + 11) begin errors++; $display("FAIL dc_latency[%0d]: got cycle %0d expected %0d", m, q_cyc[m], 8*m + 11); end
    end
    checks++; if (out_data !== 20'sd51200) begin errors++; $display("FAIL dc_hold: got %0d expected 51200", out_data); end
  endtask

  task automatic test_impulse();
    int exp_d[4] = '{1, 42, 21, 0};
    fresh();
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 7) ? 11'sd1 : 11'sd0;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (q_data.size() != 4) begin errors++; $display("FAIL imp_count: got %0d expected 4", q_data.size()); end
    for (int m = 0; m < 4 && m < q_data.size(); m++) begin
      checks++; if (q_data[m] != exp_d[m]) begin errors++; $display("FAIL imp_data[%0d]: got %0d expected %0d", m, q_data[m], exp_d[m]); end
    end
  endtask

  task automatic run_const(input int val, input int n, input int exp_q);
    int ed;
    fresh();
    in_valid = 1'b1;
    in_data  = 11'(val);
    repeat (n) step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (q_data.size() != n/8) begin errors++; $display("FAIL const_count(%0d): got %0d expected %0d", val, q_data.size(), n/8); end
    for (int m = 0; m < q_data.size(); m++) begin
      ed = (m == 0) ? 120*val : (m == 1) ? 456*val : 512*val;
      checks++; if (q_data[m] != ed) begin errors++; $display("FAIL const_data(%0d)[%0d]: got %0d expected %0d", val, m, q_data[m], ed); end
      if (m >= 2) begin
        checks++; if (q_q[m] != exp_q) begin errors++; $display("FAIL const_q(%0d)[%0d]: got %0d expected %0d", val, m, q_q[m], exp_q); end
      end
    end
  endtask

  task automatic test_extremes();
    run_const(-1024, 10000, -1024);
    run_const(1023, 2000, 1023);
  endtask

  task automatic test_gapped();
    int exp_d[6] = '{12000, 45600, 51200, 51200, 51200, 51200};
    int guard;
    fresh();
    guard = 0;
    while (n_acc < 48 && guard < 3000) begin
      in_valid = ($urandom_range(0, 99) < 30);
      in_data  = in_valid ? 11'sd100 : 11'($urandom_range(0, 2047));
      step();
      guard++;
    end
    checks++; if (n_acc < 48) begin errors++; $display("FAIL gap_timeout: got %0d accepted expected 48", n_acc); end
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (q_data.size() != 6) begin errors++; $display("FAIL gap_count: got %0d expected 6", q_data.size()); end
    for (int m = 0; m < 6 && m < q_data.size(); m++) begin
      checks++; if (q_data[m] != exp_d[m]) begin errors++; $display("FAIL gap_data[%0d]: got %0d expected %0d", m, q_data[m], exp_d[m]); end
      if (m < ev_exp.size()) begin
        checks++; if (q_cyc[m] != ev_exp[m]) begin errors++; $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", m, q_cyc[m], ev_exp[m]); end
      end
    end
  endtask

  task automatic test_clr();
    int exp_d[3] = '{12000, 45600, 51200};
    fresh();
    in_valid = 1'b1;
    in_data  = 11'sd100;
    repeat (13) step();
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL clr_pre_phase: got %0d expected 5", phase); end
    checks++; if (q_data.size() != 1) begin errors++; $display("FAIL clr_pre_count: got %0d expected 1", q_data.size()); end
    clr = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL clr_phase: got %0d expected 0", phase); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 20'sd0) begin errors++; $display("FAIL clr_data: got %0d expected 0", out_data); end
    checks++; if (out_q !== 11'sd0) begin errors++; $display("FAIL clr_q: got %0d expected 0", out_q); end
    clear_rec();
    in_valid = 1'b1;
    repeat (24) step();
    in_valid = 1'b0;
    repeat (12) step();
    checks++; if (q_data.size() != 3) begin errors++; $display("FAIL clr_count: got %0d expected 3", q_data.size()); end
    for (int m = 0; m < 3 && m < q_data.size(); m++) begin
      checks++; if (q_data[m] != exp_d[m]) begin errors++; $display("FAIL clr_data[%0d]: got %0d expected %0d", m, q_data[m], exp_d[m]); end
      checks++; if (q_cyc[m] != 8*m + 11) begin errors++; $display("FAIL clr_latency[%0d]: got cycle %0d expected %0d", m, q_cyc[m], 8*m + 11); end
    end
  endtask

  task automatic test_rst_midframe();
    int exp_d[3] = '{12000, 45600, 51200};
    int exp_q[3] = '{23, 89, 100};
    int n0;
    fresh();
    in_valid = 1'b1;
    in_data  = 11'sd100;
    repeat (16) step();
    n0 = q_data.size();
    checks++; if (n0 != 1) begin errors++; $display("FAIL rst_pre_count: got %0d expected 1", n0); end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 20'sd0) begin errors++; $display("FAIL rst_async_data: got %0d expected 0", out_data); end
    checks++; if (out_q !== 11'sd0) begin errors++; $display("FAIL rst_async_q: got %0d expected 0", out_q); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_async_phase: got %0d expected 0", phase); end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (q_data.size() != n0) begin errors++; $display("FAIL rst_inflight: got %0d outputs expected %0d", q_data.size(), n0); end
    clear_rec();
    in_valid = 1'b1;
    in_data  = 11'sd100;
    repeat (24) step();
    in_valid = 1'b0;
    repeat (4) step();
    checks++; if (q_data.size() != 3) begin errors++; $display("FAIL rst_count: got %0d expected 3", q_data.size()); end
    for (int m = 0; m < 3 && m < q_data.size(); m++) begin
      checks++; if (q_data[m] != exp_d[m]) begin errors++; $display("FAIL rst_data[%0d]: got %0d expected %0d", m, q_data[m], exp_d[m]); end
      checks++; if (q_q[m] != exp_q[m]) begin errors++; $display("FAIL rst_q[%0d]: got %0d expected %0d", m, q_q[m], exp_q[m]); end
      checks++; if (q_cyc[m] != 8*m + 11) begin errors++; $display("FAIL rst_latency[%0d]: got cycle %0d expected %0d", m, q_cyc[m], 8*m + 11); end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_extremes();
    test_gapped();
    test_clr();
    test_rst_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
